// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the neuron floating-point datapath blocks.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MAN_W-1:0] mantissa;
  } fp32_t;

endpackage

// File: rtl/fp32_lzc.sv
// Combinational 25-bit leading-zero counter; an all-zero input reports 25.
module fp32_lzc (
  input  logic [24:0] value_i,
  output logic [4:0]  count_o
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count_o = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (value_i[i]) count_o = 5'(24 - i);
    end
  end

endmodule

// File: rtl/addition_subtraction.sv
// Binary32 adder/subtractor with truncating rounding, denormal flush and a
// single registered output stage.
module addition_subtraction
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        add_sub,
  input  logic        valid_in,
  output logic        valid_out,
  output logic        exception,
  output logic [31:0] result
);

  fp32_t       a_f, b_f;
  logic        a_sign, b_sign;
  logic [23:0] a_sig, b_sig;
  logic        a_is_big;

  assign a_f    = a_operand;
  assign b_f    = b_operand;
  assign a_sign = a_f.sign;
  assign b_sign = b_f.sign ^ add_sub;
  assign a_sig  = (a_f.exponent != 8'd0) ? {1'b1, a_f.mantissa} : 24'd0;
  assign b_sig  = (b_f.exponent != 8'd0) ? {1'b1, b_f.mantissa} : 24'd0;
  assign a_is_big = {a_f.exponent, a_sig} >= {b_f.exponent, b_sig};

  logic        big_sign, small_sign;
  logic [7:0]  big_exp, small_exp, exp_diff;
  logic [23:0] big_sig, small_sig, small_aligned;
  logic [24:0] mag;
  logic [4:0]  lz;

  assign big_sign   = a_is_big ? a_sign : b_sign;
  assign small_sign = a_is_big ? b_sign : a_sign;
  assign big_exp    = a_is_big ? a_f.exponent : b_f.exponent;
  assign small_exp  = a_is_big ? b_f.exponent : a_f.exponent;
  assign big_sig    = a_is_big ? a_sig : b_sig;
  assign small_sig  = a_is_big ? b_sig : a_sig;
  assign exp_diff   = big_exp - small_exp;

  assign small_aligned = (exp_diff >= 8'd25) ? 24'd0 : (small_sig >> exp_diff);
  // Bit 24 holds the carry of an addition; a subtraction never sets it.
  assign mag = (big_sign ^ small_sign) ? {1'b0, big_sig - small_aligned}
                                       : {1'b0, big_sig} + {1'b0, small_aligned};

  fp32_lzc u_lzc (
    .value_i (mag),
    .count_o (lz)
  );

  logic [4:0]        shift_amt;
  logic signed [9:0] norm_exp;
  logic [22:0]       norm_man;
  logic [31:0]       result_d, result_q;
  logic              exc_d, exc_q, valid_q;

  always_comb begin
    shift_amt = lz - 5'd1;
    norm_exp  = '0;
    norm_man  = '0;
    result_d  = FP_ZERO;
    exc_d     = 1'b0;
    if (a_f.exponent == 8'hFF || b_f.exponent == 8'hFF) begin
      result_d = FP_QNAN;
      exc_d    = 1'b1;
    end else if (mag != 25'd0) begin
      if (lz == 5'd0) begin
        norm_exp = signed'({2'b00, big_exp}) + 10'sd1;
        norm_man = mag[23:1];
      end else begin
        norm_exp = signed'({2'b00, big_exp}) - signed'({5'b00000, shift_amt});
        norm_man = 23'(mag << shift_amt);
      end
      if (norm_exp >= 10'sd255) begin
        result_d = FP_POS_INF | {big_sign, 31'd0};
        exc_d    = 1'b1;
      end else if (norm_exp <= 10'sd0) begin
        result_d = {big_sign, 31'd0};
      end else begin
        result_d = {big_sign, norm_exp[7:0], norm_man};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= FP_ZERO;
      exc_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        result_q <= result_d;
        exc_q    <= exc_d;
      end
    end
  end

  assign result    = result_q;
  assign exception = exc_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_addition_subtraction.sv
// Randomized and directed checks of the binary32 add/sub against an
// arithmetic reference model.
module tb_addition_subtraction;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_operand, b_operand;
  logic        add_sub, valid_in;
  logic        valid_out, exception;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addition_subtraction dut (
    .clk       (clk),
    .rst       (rst),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .add_sub   (add_sub),
    .valid_in  (valid_in),
    .valid_out (valid_out),
    .exception (exception),
    .result    (result)
  );

  // Returns {exception, result} following the align/add/normalize/truncate rules.
  function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    int     ea, eb, ebig, esml, d, e;
    longint ma, mb, mbig, msml, v;
    logic   sa, sb, sbig, ssml;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, 32'h7FC00000};
    sa = a[31];
    sb = b[31] ^ op;
    ma = (ea == 0) ? 64'd0 : longint'(a[22:0]) + 64'h800000;
    mb = (eb == 0) ? 64'd0 : longint'(b[22:0]) + 64'h800000;
    if (longint'(ea) * 64'h1000000 + ma >= longint'(eb) * 64'h1000000 + mb) begin
      ebig = ea; mbig = ma; sbig = sa; esml = eb; msml = mb; ssml = sb;
    end else begin
      ebig = eb; mbig = mb; sbig = sb; esml = ea; msml = ma; ssml = sa;
    end
    d = ebig - esml;
    msml = (d >= 25) ? 64'd0 : (msml >> d);
    v = (sbig == ssml) ? mbig + msml : mbig - msml;
    if (v == 0) return {1'b0, 32'h0};
    e = ebig;
    while (v >= 64'h1000000) begin v = v >> 1; e++; end
    while (v < 64'h800000) begin v = v << 1; e--; end
    if (e >= 255) return {1'b1, sbig, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, sbig, 31'h0};
    return {1'b0, sbig, 8'(e), v[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand(input int base);
    int         sel, e;
    logic [7:0] ex;
    sel = int'($urandom_range(0, 19));
    case (sel)
      0:       e = 0;
      1:       e = 255;
      2:       e = 254;
      3:       e = 1;
      default: e = base + int'($urandom_range(0, 6)) - 3;
    endcase
    if (e < 0) e = 0;
    if (e > 255) e = 255;
    ex = 8'(e);
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic v);
    a_operand = a;
    b_operand = b;
    add_sub   = op;
    valid_in  = v;
    @(posedge clk);
    #1;
    $display("txn a=%h b=%h op=%b vin=%b -> result=%h exc=%b vout=%b",
             a, b, op, v, result, exception, valid_out);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({result, exception, valid_out} !== 34'd0) begin
      errors++;
      $display("FAIL reset_async: got result=%h exc=%b vout=%b, want 0/0/0",
               result, exception, valid_out);
    end
    valid_in = 1'b1;
    a_operand = 32'h3F800000;
    b_operand = 32'h3F800000;
    @(posedge clk);
    #1;
    checks++;
    if ({result, exception, valid_out} !== 34'd0) begin
      errors++;
      $display("FAIL reset_held: got result=%h exc=%b vout=%b, want 0/0/0",
               result, exception, valid_out);
    end
    valid_in = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [13] = '{32'h3F800000, 32'h415ED852, 32'h40400000, 32'h3F800000,
                             32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h3F800000,
                             32'h00800000, 32'h3F800000, 32'h3F800000, 32'h80000000,
                             32'h3F800000};
    logic [31:0] tb [13] = '{32'h40000000, 32'h40DED852, 32'h40400000, 32'h3F400000,
                             32'h40000000, 32'h3F800000, 32'h7F7FFFFF, 32'h7FC00000,
                             32'h00C00000, 32'h33000000, 32'h00400000, 32'h00000000,
                             32'hBF800000};
    logic        top [13] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    logic [31:0] tres [13] = '{32'h40400000, 32'h41A7223D, 32'h00000000, 32'h3E800000,
                               32'hBF800000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000,
                               32'h80000000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                               32'h00000000};
    logic        texc [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      drive(ta[i], tb[i], top[i], 1'b1);
      checks++;
      if (result !== tres[i] || exception !== texc[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL directed_%0d: got result=%h exc=%b vout=%b, want %h/%b/1",
                 i, result, exception, valid_out, tres[i], texc[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1);
    checks++;
    if (result !== 32'h7F800000 || exception !== 1'b1) begin
      errors++;
      $display("FAIL hold_setup: got result=%h exc=%b, want 7f800000/1", result, exception);
    end
    for (int i = 0; i < 3; i++) begin
      drive(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
      checks++;
      if (result !== 32'h7F800000 || exception !== 1'b1 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got result=%h exc=%b vout=%b, want 7f800000/1/0",
                 i, result, exception, valid_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic        op;
    logic [32:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      a  = rand_operand(int'($urandom_range(30, 220)));
      b  = {1'($urandom_range(0, 1)), a[30:23] - 8'(i), 23'($urandom)};
      op = 1'($urandom_range(0, 1));
      exp_v = ref_model(a, b, op);
      drive(a, b, op, 1'b1);
      checks++;
      if ({exception, result} !== exp_v || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got exc=%b result=%h vout=%b, want %b/%h/1",
                 i, exception, result, valid_out, exp_v[32], exp_v[31:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(32'h7F800000, 32'h3F800000, 1'b0, 1'b1);
    a_operand = 32'h3F800000;
    b_operand = 32'h40000000;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({result, exception, valid_out} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset_mid: got result=%h exc=%b vout=%b, want 0/0/0",
               result, exception, valid_out);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    checks++;
    if ({result, exception, valid_out} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset_after: got result=%h exc=%b vout=%b, want 0/0/0",
               result, exception, valid_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, held_res;
    logic        op, v, held_exc;
    logic [32:0] exp_v;
    held_res = 32'h0;
    held_exc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      a  = rand_operand(int'($urandom_range(2, 253)));
      if ($urandom_range(0, 3) == 0)
        b = {1'($urandom_range(0, 1)), a[30:23], a[22:8], 8'($urandom)};
      else
        b = rand_operand(int'(a[30:23]));
      op = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 4) != 0);
      if (v) begin
        exp_v    = ref_model(a, b, op);
        held_exc = exp_v[32];
        held_res = exp_v[31:0];
      end
      drive(a, b, op, v);
      checks++;
      if (result !== held_res || exception !== held_exc || valid_out !== v) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h op=%b got %h/%b/%b want %h/%b/%b",
                 i, a, b, op, result, exception, valid_out, held_res, held_exc, v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    a_operand = 32'h0;
    b_operand = 32'h0;
    add_sub   = 1'b0;
    valid_in  = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
